// File: rtl/bcd2bin_if.sv
`default_nettype none
// ============================================================================
// Module  : bcd2bin_if
// Brief   : Request/result bundle for the bcd2bin converter.
// Revision: 1.0
// ============================================================================
interface bcd2bin_if #(
   parameter int NDIG  = 4,
   parameter int NBITS = 14
);
   logic              enable;
   logic [4*NDIG-1:0] data;
   logic [NBITS-1:0]  bin;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output enable, data,
      input  bin, busy, done, err
   );

   modport slave (
      input  enable, data,
      output bin, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/bcd2bin.sv
`default_nettype none
// ============================================================================
// Module  : bcd2bin
// Brief   : Sequential BCD-to-binary converter (reverse double-dabble).
//           Define BCD_CHECK_EN to flag digits above 9 (bin forced to 0, err set).
// Revision: 1.0
// ============================================================================
module bcd2bin #(
   parameter int NDIG  = 4,
   parameter int NBITS = 14
) (
   input  logic      clkin,
   input  logic      reset,
   bcd2bin_if.slave  bus
);
   localparam int c_W  = 4 * NDIG;
   localparam int c_CW = $clog2(NBITS + 1);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(NBITS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic              w_busy_nx;
   logic              w_done_nx;
   logic              r_enable_q;
   logic              w_start;
   logic [c_W-1:0]    r_sr;
   logic [NBITS-1:0]  r_acc;
   logic [c_CW-1:0]   r_cnt;
   logic [NBITS-1:0]  r_bin;
   logic              r_busy;
   logic              r_done;
   logic [c_W-1:0]    w_sr_shift;
   logic [c_W-1:0]    w_sr_adj;
   logic [NBITS-1:0]  w_acc_shift;
   logic [NBITS-1:0]  w_bin_nx;

   assign w_start = bus.enable & ~r_enable_q;

   // One right shift of {sr,acc}, then every sr digit >= 8 loses 3.
   always_comb begin
      w_sr_shift  = {1'b0, r_sr[c_W-1:1]};
      w_acc_shift = {r_sr[0], r_acc[NBITS-1:1]};
      w_sr_adj    = w_sr_shift;
      for (int d = 0; d < NDIG; d++) begin
         if (w_sr_shift[4*d+3])
            w_sr_adj[4*d +: 4] = w_sr_shift[4*d +: 4] - 4'd3;
      end
   end

   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_busy_nx  = 1'b0;
      w_done_nx  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nx = S_SHIFT;
               w_busy_nx  = 1'b1;
            end
         end
         S_SHIFT: begin
            w_busy_nx = 1'b1;
            if (r_cnt == c_LAST) begin
               w_state_nx = S_DONE;
               w_busy_nx  = 1'b0;
               w_done_nx  = 1'b1;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

`ifdef BCD_CHECK_EN
   logic w_bad;
   logic r_bad;
   logic r_err;

   always_comb begin
      w_bad = 1'b0;
      for (int d = 0; d < NDIG; d++) begin
         if (bus.data[4*d +: 4] > 4'd9) w_bad = 1'b1;
      end
   end

   // err clears on an accepted start and is re-evaluated when the result lands.
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         r_bad <= 1'b0;
         r_err <= 1'b0;
      end else if (r_state == S_IDLE && w_start) begin
         r_bad <= w_bad;
         r_err <= 1'b0;
      end else if (r_state == S_SHIFT && r_cnt == c_LAST) begin
         r_err <= r_bad;
      end
   end

   assign w_bin_nx = r_bad ? '0 : r_acc;
   assign bus.err  = r_err;
`else
   assign w_bin_nx = r_acc;
   assign bus.err  = 1'b0;
`endif

   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         r_enable_q <= 1'b0;
         r_sr       <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_bin      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_enable_q <= bus.enable;
         r_busy     <= w_busy_nx;
         r_done     <= w_done_nx;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_sr  <= bus.data;
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            end
            S_SHIFT: begin
               if (r_cnt == c_LAST) begin
                  r_bin <= w_bin_nx;
               end else begin
                  r_sr  <= w_sr_adj;
                  r_acc <= w_acc_shift;
                  r_cnt <= r_cnt + c_CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.bin  = r_bin;
   assign bus.busy = r_busy;
   assign bus.done = r_done;
endmodule
`default_nettype wire
